eq_ui_controller: RTL



---
 rtl/eq_ui_controller.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eq_ui_controller.sv
// eq_ui_controller: front-panel menu FSM with N-band EQ gain editing, offset
// setting, up/down auto-repeat and a valid/ready channel pushing changed band
// gains to the DSP.
module eq_ui_controller #(
  parameter int unsigned N_BAND        = 7,
  parameter int unsigned GAIN_W        = 16,
  parameter int          GAIN_MAX      = 12,
  parameter int          GAIN_MIN      = -12,
  parameter int unsigned OFFSET_MAX    = 3,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_select,
  input  logic                            i_back,
  input  logic                            i_up,
  input  logic                            i_down,
  input  logic                            i_init_done,
  output logic                            o_init_start,
  output logic [2:0]                      o_state,
  output logic [1:0]                      o_menu_item,
  output logic [$clog2(N_BAND)-1:0]       o_band,
  output logic [GAIN_W-1:0]               o_gain,
  output logic [$clog2(OFFSET_MAX+1)-1:0] o_offset,
  output logic                            o_dsp_clear,
  output logic                            o_upd_valid,
  output logic [$clog2(N_BAND)-1:0]       o_upd_band,
  output logic [GAIN_W-1:0]               o_upd_gain,
  input  logic                            i_upd_ready
);

  localparam int unsigned BAND_W = $clog2(N_BAND);
  localparam int unsigned OFF_W  = $clog2(OFFSET_MAX + 1);
  localparam int unsigned CNT_W  = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  localparam logic [CNT_W-1:0]  CNT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  CNT_WRAP   = CNT_W'(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REPEAT_DELAY + 1);
  localparam logic [BAND_W-1:0] BAND_LAST  = BAND_W'(N_BAND - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'(OFFSET_MAX);
  localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_MENU       = 3'd2,
    S_BAND_SEL   = 3'd3,
    S_SET_GAIN   = 3'd4,
    S_SET_OFFSET = 3'd5,
    S_RESET      = 3'd6
  } state_t;

  logic              sel_q, sel_prev_q, back_q, back_prev_q, up_q, down_q;
  logic [CNT_W-1:0]  up_cnt_q, down_cnt_q;
  logic              ev_back, ev_sel, ev_up, ev_down;

  state_t                   state_q;
  logic                     init_start_q;
  logic [1:0]               item_q;
  logic [BAND_W-1:0]        band_q;
  logic signed [GAIN_W-1:0] gain_q [N_BAND];
  logic [OFF_W-1:0]         offset_q;
  logic                     dsp_clear_q;
  logic [N_BAND-1:0]        dirty_q;
  logic                     upd_valid_q;
  logic [BAND_W-1:0]        upd_band_q;
  logic [GAIN_W-1:0]        upd_gain_q;
  logic                     dirty_any;
  logic [BAND_W-1:0]        dirty_low;

  // Held-key counter: 0 while released, frozen while the opposite key is also held.
  function automatic logic [CNT_W-1:0] rep_next(input logic key, input logic other,
                                                input logic [CNT_W-1:0] cnt);
    if (!key)                 return '0;
    else if (other)           return cnt;
    else if (cnt == CNT_WRAP) return CNT_RELOAD;
    else                      return cnt + CNT_W'(1);
  endfunction

  // A held key fires at the edge, after the delay, then once per period.
  function automatic logic rep_hit(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) || (cnt == CNT_DELAY) || (cnt == CNT_WRAP);
  endfunction

  // Register key levels and track hold time for up/down.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q       <= 1'b0;
      sel_prev_q  <= 1'b0;
      back_q      <= 1'b0;
      back_prev_q <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      up_cnt_q    <= '0;
      down_cnt_q  <= '0;
    end else begin
      sel_q       <= i_select;
      sel_prev_q  <= sel_q;
      back_q      <= i_back;
      back_prev_q <= back_q;
      up_q        <= i_up;
      down_q      <= i_down;
      up_cnt_q    <= rep_next(up_q, down_q, up_cnt_q);
      down_cnt_q  <= rep_next(down_q, up_q, down_cnt_q);
    end
  end

  // Key events; up and down together cancel each other.
  always_comb begin
    ev_back = back_q & ~back_prev_q;
    ev_sel  = sel_q & ~sel_prev_q;
    ev_up   = up_q & ~down_q & rep_hit(up_cnt_q);
    ev_down = down_q & ~up_q & rep_hit(down_cnt_q);
  end

  // Lowest-index dirty band is offered first.
  always_comb begin
    dirty_any = |dirty_q;
    dirty_low = '0;
    for (int i = int'(N_BAND) - 1; i >= 0; i--) begin
      if (dirty_q[i]) dirty_low = BAND_W'(i);
    end
  end

  // Menu FSM, settings storage and update channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_INIT;
      init_start_q <= 1'b1;
      item_q       <= '0;
      band_q       <= '0;
      for (int i = 0; i < int'(N_BAND); i++) gain_q[i] <= '0;
      offset_q     <= '0;
      dsp_clear_q  <= 1'b0;
      dirty_q      <= '0;
      upd_valid_q  <= 1'b0;
      upd_band_q   <= '0;
      upd_gain_q   <= '0;
    end else begin
      dsp_clear_q <= 1'b0;

      // Offer slot: drop after a handshake, otherwise latch the next dirty band.
      if (upd_valid_q && i_upd_ready) begin
        upd_valid_q <= 1'b0;
      end else if (!upd_valid_q && dirty_any) begin
        upd_valid_q        <= 1'b1;
        upd_band_q         <= dirty_low;
        upd_gain_q         <= gain_q[dirty_low];
        dirty_q[dirty_low] <= 1'b0;
      end

      // Edits below are written after the clear so a re-dirtied band wins.
      case (state_q)
        S_INIT: begin
          if (i_init_done) begin
            state_q      <= S_IDLE;
            init_start_q <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!ev_back && ev_sel) begin
            state_q <= S_MENU;
            item_q  <= '0;
          end
        end
        S_MENU: begin
          if (ev_back) begin
            state_q <= S_IDLE;
          end else if (ev_sel) begin
            case (item_q)
              2'd0: begin
                state_q <= S_BAND_SEL;
                band_q  <= '0;
              end
              2'd1: state_q <= S_SET_OFFSET;
              default: begin
                for (int i = 0; i < int'(N_BAND); i++) gain_q[i] <= '0;
                offset_q    <= '0;
                dirty_q     <= '1;
                dsp_clear_q <= 1'b1;
                state_q     <= S_RESET;
              end
            endcase
          end else if (ev_up) begin
            if (item_q < 2'd2) item_q <= item_q + 2'd1;
          end else if (ev_down) begin
            if (item_q > 2'd0) item_q <= item_q - 2'd1;
          end
        end
        S_RESET: state_q <= S_MENU;
        S_BAND_SEL: begin
          if (ev_back) begin
            state_q <= S_MENU;
          end else if (ev_sel) begin
            state_q <= S_SET_GAIN;
          end else if (ev_up) begin
            if (band_q < BAND_LAST) band_q <= band_q + BAND_W'(1);
          end else if (ev_down) begin
            if (band_q > '0) band_q <= band_q - BAND_W'(1);
          end
        end
        S_SET_GAIN: begin
          if (ev_back || ev_sel) begin
            state_q <= S_BAND_SEL;
          end else if (ev_up) begin
            if (gain_q[band_q] < G_MAX) begin
              gain_q[band_q]  <= gain_q[band_q] + GAIN_W'(1);
              dirty_q[band_q] <= 1'b1;
            end
          end else if (ev_down) begin
            if (gain_q[band_q] > G_MIN) begin
              gain_q[band_q]  <= gain_q[band_q] - GAIN_W'(1);
              dirty_q[band_q] <= 1'b1;
            end
          end
        end
        S_SET_OFFSET: begin
          if (ev_back || ev_sel) begin
            state_q <= S_MENU;
          end else if (ev_up) begin
            if (offset_q < OFF_LAST) offset_q <= offset_q + OFF_W'(1);
          end else if (ev_down) begin
            if (offset_q > '0) offset_q <= offset_q - OFF_W'(1);
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign o_init_start = init_start_q;
  assign o_state      = state_q;
  assign o_menu_item  = item_q;
  assign o_band       = band_q;
  assign o_gain       = gain_q[band_q];
  assign o_offset     = offset_q;
  assign o_dsp_clear  = dsp_clear_q;
  assign o_upd_valid  = upd_valid_q;
  assign o_upd_band   = upd_band_q;
  assign o_upd_gain   = upd_gain_q;

endmodule
